// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, lane id, FSM states and response tag for the JAM cost-table arbiter
package jam_pkg;

    localparam int IDX_W  = 3;
    localparam int COST_W = 7;

    typedef logic lane_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic  valid;
        lane_t lane;
    } tag_t;

endpackage

// File: rtl/jam_rsp_pipe.sv
// jam_rsp_pipe: LAT-deep tag delay line; output tag lines up with the edge that samples Cost
module jam_rsp_pipe
    import jam_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic CLK,
    input  logic RST,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t sr [LAT];

    always_ff @(posedge CLK) begin
        for (int i = LAT - 1; i > 0; i--) sr[i] <= RST ? '0 : sr[i-1];
        sr[0] <= RST ? '0 : tag_in;
    end

    assign tag_out = sr[LAT-1];

endmodule

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: burst-locked round-robin sharing of one cost-table port between two JAM lanes
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int COST_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    input  logic [IDX_W-1:0]  req0_w,
    input  logic [IDX_W-1:0]  req0_j,
    input  logic              req0_last,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [COST_W-1:0] rsp0_cost,
    input  logic              req1_valid,
    input  logic [IDX_W-1:0]  req1_w,
    input  logic [IDX_W-1:0]  req1_j,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [COST_W-1:0] rsp1_cost,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost
);

    state_t            state, state_nx;
    lane_t             last_owner;
    logic              acc0, acc1, burst_end;
    tag_t              push, tag_s, tag_q;
    logic [COST_W-1:0] cost_q;

    assign req0_ready = state == ST_GRANT0;
    assign req1_ready = state == ST_GRANT1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign burst_end  = (acc0 & req0_last) | (acc1 & req1_last);
    assign push       = '{valid: acc0 | acc1, lane: acc1};

    // Ties go to the lane that did not own the previous burst
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = (req0_valid & (~req1_valid | last_owner)) ? ST_GRANT0 :
                                  req1_valid ? ST_GRANT1 : ST_IDLE;
            ST_GRANT0: state_nx = !(acc0 & req0_last) ? ST_GRANT0 :
                                  req1_valid ? ST_GRANT1 : ST_IDLE;
            ST_GRANT1: state_nx = !(acc1 & req1_last) ? ST_GRANT1 :
                                  req0_valid ? ST_GRANT0 : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    jam_rsp_pipe #(.LAT(COST_LAT)) u_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .tag_in  (push),
        .tag_out (tag_s)
    );

    // Cost is captured with its tag, then demuxed one edge later
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            W          <= '0;
            J          <= '0;
            tag_q      <= '0;
            cost_q     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_cost  <= '0;
            rsp1_cost  <= '0;
        end else begin
            state  <= state_nx;
            tag_q  <= tag_s;
            cost_q <= Cost;
            if (burst_end) last_owner <= acc1;
            if (acc0 | acc1) begin
                W <= acc1 ? req1_w : req0_w;
                J <= acc1 ? req1_j : req0_j;
            end
            rsp0_valid <= tag_q.valid & (tag_q.lane == 1'b0);
            rsp1_valid <= tag_q.valid & (tag_q.lane == 1'b1);
            if (tag_q.valid & (tag_q.lane == 1'b0)) rsp0_cost <= cost_q;
            if (tag_q.valid & (tag_q.lane == 1'b1)) rsp1_cost <= cost_q;
        end
    end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: directed vectors for jam_cost_arbiter (COST_LAT=1 and COST_LAT=2 instances)
module tb_jam_cost_arbiter;

    localparam int NOGAP = -1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [2:0] req0_w = '0, req0_j = '0, req1_w = '0, req1_j = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [6:0] rsp0_cost, rsp1_cost, Cost;
    logic [2:0] W, J;
    logic       req0_ready2, req1_ready2, rsp0_valid2, rsp1_valid2;
    logic [6:0] rsp0_cost2, rsp1_cost2, Cost2, c2q;
    logic [2:0] W2, J2;

    int cyc = 0, n_vec = 0, n_bad = 0;
    int q0[$], q1[$], t0[$], t1[$], q20[$], q21[$], t21[$];
    int acc_ln[$], acc_e[$];

    function automatic logic [6:0] cost_f(input logic [2:0] w, input logic [2:0] j);
        return 7'(int'(w) * 10 + int'(j));
    endfunction

    assign Cost  = cost_f(W, J);
    assign Cost2 = c2q;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        c2q <= cost_f(W2, J2);
    end

    always @(negedge CLK) begin
        if (rsp0_valid) begin q0.push_back(int'(rsp0_cost)); t0.push_back(cyc); end
        if (rsp1_valid) begin q1.push_back(int'(rsp1_cost)); t1.push_back(cyc); end
        if (rsp0_valid2) q20.push_back(int'(rsp0_cost2));
        if (rsp1_valid2) begin q21.push_back(int'(rsp1_cost2)); t21.push_back(cyc); end
    end

    jam_cost_arbiter #(.COST_LAT(1)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_w(req0_w), .req0_j(req0_j), .req0_last(req0_last),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_cost(rsp0_cost),
        .req1_valid(req1_valid), .req1_w(req1_w), .req1_j(req1_j), .req1_last(req1_last),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_cost(rsp1_cost),
        .W(W), .J(J), .Cost(Cost)
    );

    jam_cost_arbiter #(.COST_LAT(2)) dut2 (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_w(req0_w), .req0_j(req0_j), .req0_last(req0_last),
        .req0_ready(req0_ready2), .rsp0_valid(rsp0_valid2), .rsp0_cost(rsp0_cost2),
        .req1_valid(req1_valid), .req1_w(req1_w), .req1_j(req1_j), .req1_last(req1_last),
        .req1_ready(req1_ready2), .rsp1_valid(rsp1_valid2), .rsp1_cost(rsp1_cost2),
        .W(W2), .J(J2), .Cost(Cost2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int first_acc(input int ln);
        foreach (acc_ln[k]) if (acc_ln[k] == ln) return acc_e[k];
        return -100;
    endfunction

    function automatic int last_acc(input int ln);
        int r = -100;
        foreach (acc_ln[k]) if (acc_ln[k] == ln) r = acc_e[k];
        return r;
    endfunction

    task automatic clear_logs();
        q0.delete(); q1.delete(); t0.delete(); t1.delete();
        q20.delete(); q21.delete(); t21.delete();
        acc_ln.delete(); acc_e.delete();
    endtask

    task automatic set_req(input int ln, input logic v, input logic [2:0] w, input logic [2:0] j, input logic l);
        if (ln == 0) begin
            req0_valid = v; req0_w = w; req0_j = j; req0_last = l;
        end else begin
            req1_valid = v; req1_w = w; req1_j = j; req1_last = l;
        end
    endtask

    // Called at a negedge; returns at the negedge after the n-th accept, valid still driven
    task automatic drive(input int ln, input int n, input int w0, input int jj, input bit use_last, input int gap_at);
        int   i = 0, waits = 0, e;
        bit   gapped = 0;
        logic rdy;
        while (i < n) begin
            if (i == gap_at && !gapped) begin
                gapped = 1;
                set_req(ln, 1'b0, 3'd0, 3'd0, 1'b0);
                repeat (3) begin
                    @(posedge CLK);
                    @(negedge CLK);
                    chk("gap_hold_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
                end
            end
            set_req(ln, 1'b1, 3'(w0 + i), 3'(jj), use_last && (i == n - 1));
            rdy = (ln == 0) ? req0_ready : req1_ready;
            e   = cyc + 1;
            @(posedge CLK);
            if (rdy) begin
                acc_ln.push_back(ln);
                acc_e.push_back(e);
                i++;
                waits = 0;
            end else begin
                waits++;
                if (waits > 100) begin
                    chk("drive_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            @(negedge CLK);
        end
    endtask

    task automatic check_lane(input string tag, input int q[$], input int j, input int n);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++) chk(tag, at(q, i), 10 * i + j);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_W", W, 0);
        chk("rst_J", J, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_cost", rsp0_cost, 0);
        chk("rst_rsp1_cost", rsp1_cost, 0);
        chk("rst_ready2", {req1_ready2, req0_ready2}, 0);
        RST = 1'b0;

        // lane 0 alone, 8 queries
        clear_logs();
        drive(0, 8, 0, 3, 1, NOGAP);
        set_req(0, 1'b0, 3'd0, 3'd0, 1'b0);
        repeat (8) @(negedge CLK);
        check_lane("t1_rsp0", q0, 3, 8);
        chk("t1_rsp1_none", q1.size(), 0);
        chk("t1_latency", at(t0, 0), at(acc_e, 0) + 2);
        chk("t1_back_to_back", at(t0, 7) - at(t0, 0), 7);

        // both lanes valid out of reset
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        clear_logs();
        fork
            begin drive(0, 8, 0, 1, 1, NOGAP); set_req(0, 1'b0, 3'd0, 3'd0, 1'b0); end
            begin drive(1, 8, 0, 5, 1, NOGAP); set_req(1, 1'b0, 3'd0, 3'd0, 1'b0); end
        join
        repeat (8) @(negedge CLK);
        chk("t2_lane0_first", first_acc(0) < first_acc(1), 1);
        chk("t2_no_bubble_switch", first_acc(1), last_acc(0) + 1);
        check_lane("t2_rsp0", q0, 1, 8);
        check_lane("t2_rsp1", q1, 5, 8);
        chk("t2_rsp_lane_switch", at(t1, 0), at(t0, 7) + 1);

        // following tie goes back to lane 0
        clear_logs();
        fork
            begin drive(0, 1, 1, 0, 1, NOGAP); set_req(0, 1'b0, 3'd0, 3'd0, 1'b0); end
            begin drive(1, 1, 2, 0, 1, NOGAP); set_req(1, 1'b0, 3'd0, 3'd0, 1'b0); end
        join
        repeat (8) @(negedge CLK);
        chk("t2_tie_first", at(acc_ln, 0), 0);
        chk("t2_tie_second", at(acc_ln, 1), 1);
        chk("t2_tie_rsp0", at(q0, 0), 10);
        chk("t2_tie_rsp1", at(q1, 0), 20);

        // lane 0 stalls mid-burst while lane 1 waits
        clear_logs();
        fork
            begin drive(0, 8, 0, 2, 1, 4); set_req(0, 1'b0, 3'd0, 3'd0, 1'b0); end
            begin drive(1, 8, 0, 7, 1, NOGAP); set_req(1, 1'b0, 3'd0, 3'd0, 1'b0); end
        join
        repeat (8) @(negedge CLK);
        chk("t3_stall_gap", at(acc_e, 4) - at(acc_e, 3), 4);
        chk("t3_lane1_after", first_acc(1), last_acc(0) + 1);
        check_lane("t3_rsp0", q0, 2, 8);
        check_lane("t3_rsp1", q1, 7, 8);

        // alternating single-query bursts
        clear_logs();
        fork
            begin
                for (int k = 0; k < 4; k++) drive(0, 1, k, 2, 1, NOGAP);
                set_req(0, 1'b0, 3'd0, 3'd0, 1'b0);
            end
            begin
                for (int k = 0; k < 4; k++) drive(1, 1, k, 4, 1, NOGAP);
                set_req(1, 1'b0, 3'd0, 3'd0, 1'b0);
            end
        join
        repeat (8) @(negedge CLK);
        for (int k = 0; k < 8; k++) chk("t4_grant_order", at(acc_ln, k), k % 2);
        chk("t4_no_bubbles", at(acc_e, 7) - at(acc_e, 0), 7);
        check_lane("t4_rsp0", q0, 2, 4);
        check_lane("t4_rsp1", q1, 4, 4);

        // reset one cycle after 3 accepts drops all pending responses
        clear_logs();
        drive(0, 3, 4, 6, 0, NOGAP);
        set_req(0, 1'b0, 3'd0, 3'd0, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        clear_logs();
        @(negedge CLK);
        chk("t5_W", W, 0);
        chk("t5_J", J, 0);
        chk("t5_idle_ready", {req1_ready, req0_ready}, 0);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        chk("t5_no_rsp0", q0.size(), 0);
        chk("t5_no_rsp1", q1.size(), 0);
        clear_logs();
        fork
            begin drive(0, 1, 3, 3, 1, NOGAP); set_req(0, 1'b0, 3'd0, 3'd0, 1'b0); end
            begin drive(1, 1, 6, 1, 1, NOGAP); set_req(1, 1'b0, 3'd0, 3'd0, 1'b0); end
        join
        repeat (8) @(negedge CLK);
        chk("t5_tie_lane0", at(acc_ln, 0), 0);
        chk("t5_rsp0", at(q0, 0), 33);
        chk("t5_rsp1", at(q1, 0), 61);

        // COST_LAT=2 instance, lane 1 burst of 4
        clear_logs();
        drive(1, 4, 0, 6, 1, NOGAP);
        set_req(1, 1'b0, 3'd0, 3'd0, 1'b0);
        repeat (8) @(negedge CLK);
        check_lane("t6_lat2_rsp1", q21, 6, 4);
        chk("t6_lat2_latency", at(t21, 0), at(acc_e, 0) + 3);
        chk("t6_lat2_back_to_back", at(t21, 3) - at(t21, 0), 3);
        chk("t6_lat2_rsp0_none", q20.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jam_cost_arbiter.md
Name: jam_cost_arbiter

Overview:
- Shares the single cost-table port (W/J out, Cost in) between two permutation-evaluation lanes of a dual-lane JAM engine.
- Each lane issues bursts of worker/job queries, normally 8 per permutation; the last query of a burst is flagged with req_last.
- Grant is round-robin per burst: a lane keeps the port until its last query is accepted.
- Returned Cost values are tagged and routed back to the lane that issued the query, in issue order.

Parameters:
- COST_LAT, 1: cycles between W/J being driven and Cost being valid for sampling (≥1).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req0_valid  in  1  lane 0 query request.
- req0_w  in  3  lane 0 worker index.
- req0_j  in  3  lane 0 job index.
- req0_last  in  1  lane 0 final query of burst.
- req0_ready  out  1  lane 0 query accepted this cycle when high with valid.
- rsp0_valid  out  1  lane 0 cost return strobe.
- rsp0_cost  out  7  lane 0 returned cost.
- req1_valid, req1_w, req1_j, req1_last, req1_ready, rsp1_valid, rsp1_cost: as lane 0, for lane 1.
- W  out  3  cost-table worker index (registered).
- J  out  3  cost-table job index (registered).
- Cost  in  7  cost-table data.

Behaviour:
- Reset values:
  - state=IDLE; last_owner=1, so lane 0 wins the first tie.
  - W=0, J=0.
  - reqX_ready=0, rspX_valid=0, rspX_cost=0.
  - All in-flight tags are cleared.
- Reset mid-burst drops every pending response; no rsp strobe appears after RST.
- FSM states:
  - IDLE, GRANT0, GRANT1, encoded 2 bits.
  - reqX_ready = (state==GRANTX), decoded from state only; it never depends on reqX_valid.
- IDLE:
  - Never accepts a request.
  - If only lane k is valid: next state GRANTk.
  - If both are valid: grant the lane ≠ last_owner.
  - If neither is valid: stay in IDLE.
  - The IDLE→GRANT transition costs one bubble cycle.
- GRANTk:
  - Accept = reqk_valid & reqk_ready.
  - On accept: W←reqk_w, J←reqk_j; push tag {valid=1, lane=k} into the delay line.
  - If accept with last=1: last_owner←k. Next state is GRANT(other) if the other lane's valid is high that cycle (no bubble), else IDLE.
  - While reqk_valid is low, or last has not been accepted, hold GRANTk. The lock is held and the other lane waits indefinitely.
- W/J hold their last value when nothing is accepted.
- Response timing:
  - Request accepted at edge t; W/J are valid from t.
  - Cost is sampled at edge t+COST_LAT.
  - rspk_valid=1 and rspk_cost=sampled Cost during the cycle following edge t+COST_LAT, i.e. end-to-end latency is COST_LAT+1 edges.
  - rspk_valid is a single-cycle strobe per accepted query.
- Responses are in acceptance order and have no backpressure; lanes must consume them.
  - Back-to-back accepts yield back-to-back strobes.
  - The lane switch at a burst boundary yields strobes on different lanes in consecutive cycles.
- The non-owning lane's rsp_cost holds its previous value; only the valid strobe qualifies it.
- reqX_last on a non-accepted cycle is ignored.
- A burst of length 1 (last on the first query) is legal.
- Arithmetic: none beyond tag routing; Cost passes unmodified (7 bits).

Decomposition:
- Package jam_pkg:
  - Widths IDX_W=3, COST_W=7.
  - Lane-id type (1 bit).
  - FSM state localparams ST_IDLE, ST_GRANT0, ST_GRANT1.
- Sub-module jam_rsp_pipe: a COST_LAT-deep shift register of {valid, lane}, synchronous clear on RST. It outputs the tag aligned with the Cost sample edge.
- The arbiter FSM, W/J registers and the response demux stay in jam_cost_arbiter.

Test Plan:
- Lane 0 only, 8 queries (w=0..7, j=3, last on the 8th), table Cost=w*10+j → rsp0 strobes 8 consecutive cycles with costs 3,13,…,73, starting COST_LAT+1 edges after the first accept; rsp1_valid stays 0.
- Both lanes valid out of reset, 8-query bursts each → lane 0 is served first. Lane 1 is granted the cycle after lane 0's last accept, with no bubble, and gets 8 responses. A following tie grants lane 0 again.
- Lane 0 drops valid for 3 cycles mid-burst (after 4 queries) while lane 1 is valid → req1_ready stays 0 and lane 0 keeps the grant. Lane 0's remaining 4 queries complete, then lane 1 is granted.
- Single-query bursts alternating from both lanes (last=1 every request) → grants alternate 0,1,0,1; each response lands on the correct lane.
- RST asserted one cycle after 3 accepted queries → no rsp strobe follows. W=J=0, state IDLE; the first request after reset goes to lane 0 on a tie.
- COST_LAT=2 build, lane 1 burst of 4 → strobes begin 3 edges after the first accept, with the correct cost ordering.
